// File: rtl/decode_cycle_pkg.sv
// decode_cycle_pkg
//   Shared constants and types for the Decode stage: opcode values, ALUOp
//   codes, ALUControl codes, immediate-source selections and the bundled
//   main-decoder control word.
package decode_cycle_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    ALUC_ADD = 3'b000,
    ALUC_SUB = 3'b001,
    ALUC_AND = 3'b010,
    ALUC_OR  = 3'b011,
    ALUC_SLT = 3'b101
  } alu_ctrl_e;

  // IMM_NONE marks opcodes without an immediate; the extender yields zero.
  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_NONE = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic     reg_write;
    logic     alu_src;
    logic     mem_write;
    logic     result_src;
    logic     branch;
    imm_src_e imm_src;
    alu_op_e  alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{reg_write: 1'b0, alu_src: 1'b0, mem_write: 1'b0,
                                  result_src: 1'b0, branch: 1'b0,
                                  imm_src: IMM_NONE, alu_op: ALUOP_ADD};

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile
//   32 x 32-bit register file with two combinational read ports and one
//   clocked write port. x0 is hard-wired to zero; a read of the register
//   being written this cycle returns the write data (write-through bypass).
// Ports:
//   clk      rising-edge write clock
//   rst      asynchronous active-low reset, clears every register
//   ra1/ra2  read addresses         rd1/rd2  read data
//   we/wa/wd write enable, address, data
module decode_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_r [32];
  logic        wr_en_s;

  assign wr_en_s = we && (wa != 5'd0);

  // Register storage: cleared on reset, written on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end
  end

  // Read port 1 with x0 forcing and same-cycle write bypass.
  always_comb begin
    rd1 = 32'd0;
    if (ra1 == 5'd0) begin
      rd1 = 32'd0;
    end else if (wr_en_s && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_r[ra1];
    end
  end

  // Read port 2 with x0 forcing and same-cycle write bypass.
  always_comb begin
    rd2 = 32'd0;
    if (ra2 == 5'd0) begin
      rd2 = 32'd0;
    end else if (wr_en_s && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_r[ra2];
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle
//   Decode stage of a five-stage RV32I subset pipeline: main control
//   decoder, ALU decoder, immediate extender, register file and the ID/EX
//   pipeline register.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   InstrD, PCD, PCPlus4D          Decode-stage instruction and PCs
//   RegWriteW, RDW, ResultW        writeback port into the register file
//   *E outputs                     registered Execute-stage values
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [4:0]  RD_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        funct7b5_s;
  ctrl_t       ctrl_s;
  alu_ctrl_e   alu_ctrl_s;
  logic [31:0] imm_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;

  assign opcode_s   = InstrD[6:0];
  assign funct3_s   = InstrD[14:12];
  assign funct7b5_s = InstrD[30];

  // Main control decoder; unknown opcodes produce all-zero controls.
  always_comb begin
    ctrl_s = CTRL_NONE;
    case (opcode_s)
      OP_LW:    ctrl_s = '{reg_write: 1'b1, alu_src: 1'b1, mem_write: 1'b0, result_src: 1'b1,
                           branch: 1'b0, imm_src: IMM_I, alu_op: ALUOP_ADD};
      OP_SW:    ctrl_s = '{reg_write: 1'b0, alu_src: 1'b1, mem_write: 1'b1, result_src: 1'b0,
                           branch: 1'b0, imm_src: IMM_S, alu_op: ALUOP_ADD};
      OP_RTYPE: ctrl_s = '{reg_write: 1'b1, alu_src: 1'b0, mem_write: 1'b0, result_src: 1'b0,
                           branch: 1'b0, imm_src: IMM_NONE, alu_op: ALUOP_FUNCT};
      OP_IALU:  ctrl_s = '{reg_write: 1'b1, alu_src: 1'b1, mem_write: 1'b0, result_src: 1'b0,
                           branch: 1'b0, imm_src: IMM_I, alu_op: ALUOP_FUNCT};
      OP_BEQ:   ctrl_s = '{reg_write: 1'b0, alu_src: 1'b0, mem_write: 1'b0, result_src: 1'b0,
                           branch: 1'b1, imm_src: IMM_B, alu_op: ALUOP_SUB};
      default:  ctrl_s = CTRL_NONE;
    endcase
  end

  // ALU decoder; subtract only for R-type with funct7[5] set, so an
  // I-type immediate that happens to have bit 30 set still adds.
  always_comb begin
    alu_ctrl_s = ALUC_ADD;
    case (ctrl_s.alu_op)
      ALUOP_ADD: alu_ctrl_s = ALUC_ADD;
      ALUOP_SUB: alu_ctrl_s = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3_s)
          3'b000: begin
            if (opcode_s[5] && funct7b5_s) begin
              alu_ctrl_s = ALUC_SUB;
            end else begin
              alu_ctrl_s = ALUC_ADD;
            end
          end
          3'b010:  alu_ctrl_s = ALUC_SLT;
          3'b110:  alu_ctrl_s = ALUC_OR;
          3'b111:  alu_ctrl_s = ALUC_AND;
          default: alu_ctrl_s = ALUC_ADD;
        endcase
      end
      default: alu_ctrl_s = ALUC_ADD;
    endcase
  end

  // Immediate extender, sign bit is always InstrD[31].
  always_comb begin
    imm_s = 32'd0;
    case (ctrl_s.imm_src)
      IMM_I:   imm_s = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_s = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                        InstrD[11:8], 1'b0};
      default: imm_s = 32'd0;
    endcase
  end

  decode_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (InstrD[19:15]),
    .ra2 (InstrD[24:20]),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .rd1 (rd1_s),
    .rd2 (rd2_s)
  );

  // ID/EX pipeline register; register fields are captured for every opcode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1_E       <= 32'd0;
      RD2_E       <= 32'd0;
      Imm_Ext_E   <= 32'd0;
      RS1_E       <= 5'd0;
      RS2_E       <= 5'd0;
      RD_E        <= 5'd0;
      PCE         <= 32'd0;
      PCPlus4E    <= 32'd0;
    end else begin
      RegWriteE   <= ctrl_s.reg_write;
      ALUSrcE     <= ctrl_s.alu_src;
      MemWriteE   <= ctrl_s.mem_write;
      ResultSrcE  <= ctrl_s.result_src;
      BranchE     <= ctrl_s.branch;
      ALUControlE <= alu_ctrl_s;
      RD1_E       <= rd1_s;
      RD2_E       <= rd2_s;
      Imm_Ext_E   <= imm_s;
      RS1_E       <= InstrD[19:15];
      RS2_E       <= InstrD[24:20];
      RD_E        <= InstrD[11:7];
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle
//   Self-checking bench for decode_cycle: a table of hand-decoded vectors,
//   hand-written register-file and reset sequences, and randomized
//   instructions compared against a behavioural model kept here.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E;
  logic [4:0]  RS1_E, RS2_E, RD_E;
  logic [31:0] PCE, PCPlus4E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw, alusrc, mw, rsrc, br;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4;
  } eout_t;

  typedef struct {
    logic [31:0] ins, pc, pc4;
    eout_t       exp;
  } vec_t;

  eout_t       act;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rf [32];
  vec_t        tbl [12];

  assign act = {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
                RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E};

  task automatic check(input string name, input eout_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic eout_t mkexp(logic rw, logic alusrc, logic mw, logic rsrc, logic br,
                                  logic [2:0] aluc, logic [31:0] imm, logic [4:0] rs1,
                                  logic [4:0] rs2, logic [4:0] rd, logic [31:0] pc,
                                  logic [31:0] pc4);
    eout_t e;
    e = '0;
    e.rw = rw; e.alusrc = alusrc; e.mw = mw; e.rsrc = rsrc; e.br = br; e.aluc = aluc;
    e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.pc = pc; e.pc4 = pc4;
    return e;
  endfunction

  // Register read as seen by the instruction in Decode this cycle.
  function automatic logic [31:0] model_read(logic [4:0] r, logic we, logic [4:0] wa,
                                             logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return model_rf[r];
  endfunction

  // Behavioural decode from the instruction-set rules, immediates by arithmetic.
  function automatic eout_t model(logic [31:0] ins, logic [31:0] pc, logic [31:0] pc4,
                                  logic we, logic [4:0] wa, logic [31:0] wd);
    eout_t e;
    int    kind;   // 0 none, 1 I, 2 S, 3 B
    int    aluop;  // 0 add, 1 sub, 2 by funct
    int    v;
    e = '0; kind = 0; aluop = 0; v = 0;
    case (ins[6:0])
      7'b0000011: begin e.rw = 1'b1; e.alusrc = 1'b1; e.rsrc = 1'b1; kind = 1; end
      7'b0100011: begin e.mw = 1'b1; e.alusrc = 1'b1; kind = 2; end
      7'b0110011: begin e.rw = 1'b1; aluop = 2; end
      7'b0010011: begin e.rw = 1'b1; e.alusrc = 1'b1; kind = 1; aluop = 2; end
      7'b1100011: begin e.br = 1'b1; kind = 3; aluop = 1; end
      default: begin end
    endcase
    if (aluop == 1) e.aluc = 3'b001;
    else if (aluop == 2) begin
      case (ins[14:12])
        3'b000: e.aluc = (ins[5] && ins[30]) ? 3'b001 : 3'b000;
        3'b010: e.aluc = 3'b101;
        3'b110: e.aluc = 3'b011;
        3'b111: e.aluc = 3'b010;
        default: e.aluc = 3'b000;
      endcase
    end
    if (kind == 1) begin
      v = int'(ins[31:20]);
      if (v >= 2048) v -= 4096;
    end else if (kind == 2) begin
      v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
      if (v >= 2048) v -= 4096;
    end else if (kind == 3) begin
      v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
          int'(ins[11:8]) * 2;
      if (v >= 4096) v -= 8192;
    end
    e.imm = v;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.rd1 = model_read(ins[19:15], we, wa, wd);
    e.rd2 = model_read(ins[24:20], we, wa, wd);
    e.pc  = pc;
    e.pc4 = pc4;
    return e;
  endfunction

  // One Decode cycle: drive, predict, clock, update model file, compare.
  task automatic step(input string name, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    eout_t exp;
    InstrD = ins; PCD = pc; PCPlus4D = pc4; RegWriteW = we; RDW = wa; ResultW = wd;
    exp = model(ins, pc, pc4, we, wa, wd);
    @(posedge clk);
    if (we && wa != 5'd0) model_rf[wa] = wd;
    #1;
    check(name, exp);
  endtask

  initial begin
    tbl[0]  = '{32'h003100B3, 32'h0,   32'h4,   mkexp(1,0,0,0,0,3'b000,32'h0,       5'd2,5'd3, 5'd1, 32'h0,  32'h4)};
    tbl[1]  = '{32'h00812203, 32'h100, 32'h104, mkexp(1,1,0,1,0,3'b000,32'h8,       5'd2,5'd8, 5'd4, 32'h100,32'h104)};
    tbl[2]  = '{32'h00312623, 32'h200, 32'h204, mkexp(0,1,1,0,0,3'b000,32'hC,       5'd2,5'd3, 5'd12,32'h200,32'h204)};
    tbl[3]  = '{32'h00310863, 32'h300, 32'h304, mkexp(0,0,0,0,1,3'b001,32'h10,      5'd2,5'd3, 5'd16,32'h300,32'h304)};
    tbl[4]  = '{32'h407302B3, 32'h400, 32'h404, mkexp(1,0,0,0,0,3'b001,32'h0,       5'd6,5'd7, 5'd5, 32'h400,32'h404)};
    tbl[5]  = '{32'h40000093, 32'h500, 32'h504, mkexp(1,1,0,0,0,3'b000,32'h400,     5'd0,5'd0, 5'd1, 32'h500,32'h504)};
    tbl[6]  = '{32'hFFF08093, 32'h600, 32'h604, mkexp(1,1,0,0,0,3'b000,32'hFFFFFFFF,5'd1,5'd31,5'd1, 32'h600,32'h604)};
    tbl[7]  = '{32'hFFFFFFFF, 32'h700, 32'h704, mkexp(0,0,0,0,0,3'b000,32'h0,       5'd31,5'd31,5'd31,32'h700,32'h704)};
    tbl[8]  = '{32'h00316233, 32'h800, 32'h804, mkexp(1,0,0,0,0,3'b011,32'h0,       5'd2,5'd3, 5'd4, 32'h800,32'h804)};
    tbl[9]  = '{32'h00312233, 32'h900, 32'h904, mkexp(1,0,0,0,0,3'b101,32'h0,       5'd2,5'd3, 5'd4, 32'h900,32'h904)};
    tbl[10] = '{32'hFF017213, 32'hA00, 32'hA04, mkexp(1,1,0,0,0,3'b010,32'hFFFFFFF0,5'd2,5'd16,5'd4, 32'hA00,32'hA04)};
    tbl[11] = '{32'hFE208CE3, 32'hB00, 32'hB04, mkexp(0,0,0,0,1,3'b001,32'hFFFFFFF8,5'd1,5'd2, 5'd25,32'hB00,32'hB04)};

    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    // Reset with arbitrary inputs, including a pending write.
    rst = 1'b1;
    InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    RegWriteW = 1'b1; RDW = 5'd7; ResultW = $urandom;
    #1 rst = 1'b0;
    #10;
    check("reset_10ns", '0);
    @(posedge clk); #1;
    check("reset_hold", '0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), tbl[i].ins, tbl[i].pc, tbl[i].pc4, 1'b0, 5'd0, 32'd0);
      check(vec_name(i), tbl[i].exp);
    end

    // Writeback into x2, read by an rs1=x2 instruction in the same cycle.
    step("wb_bypass", 32'h00010293, 32'h10, 32'h14, 1'b1, 5'd2, 32'hAABBCCDD);
    check32("wb_bypass_rd1", RD1_E, 32'hAABBCCDD);
    step("wb_held", 32'h00010293, 32'h14, 32'h18, 1'b0, 5'd0, 32'd0);
    check32("wb_held_rd1", RD1_E, 32'hAABBCCDD);
    step("x0_write", 32'h00000093, 32'h18, 32'h1C, 1'b1, 5'd0, 32'h12345678);
    check32("x0_write_rd1", RD1_E, 32'd0);
    step("x0_after", 32'h00000093, 32'h1C, 32'h20, 1'b0, 5'd0, 32'd0);
    check32("x0_after_rd1", RD1_E, 32'd0);

    // Randomized instructions and writebacks.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [4:0]  wa;
      int          sel;
      ins = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: ins[6:0] = 7'b0000011;
        1: ins[6:0] = 7'b0100011;
        2: ins[6:0] = 7'b0110011;
        3: ins[6:0] = 7'b0010011;
        4: ins[6:0] = 7'b1100011;
        default: begin end
      endcase
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ins[19:15] = wa;
      if ($urandom_range(0, 3) == 0) ins[24:20] = wa;
      step("random", ins, $urandom, $urandom, 1'($urandom_range(0, 1)), wa, $urandom);
    end

    // Reset mid-operation clears the file and overrides a pending write.
    step("pre_reset_wr", 32'h00010293, 32'h40, 32'h44, 1'b1, 5'd2, 32'h13572468);
    check32("pre_reset_rd1", RD1_E, 32'h13572468);
    InstrD = 32'h00010293; RegWriteW = 1'b1; RDW = 5'd2; ResultW = 32'h55;
    #2 rst = 1'b0;
    #1 check("reset_async", '0);
    @(posedge clk); #1;
    check("reset_midop_hold", '0);
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    step("post_reset_rd", 32'h00010293, 32'h50, 32'h54, 1'b0, 5'd0, 32'd0);
    check32("post_reset_rd1", RD1_E, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic string vec_name(int i);
    return $sformatf("tbl%0d", i);
  endfunction

endmodule
